// File: rtl/division_seq.sv
// division_seq: radix-2 restoring divider, one quotient bit per clock.
// Handshake: start is accepted on a rising edge while ready=1. Results then
// stay registered and valid while ready=1, and done pulses once on the edge
// where they are written.
// A zero divisor is flagged one cycle after acceptance. The quotient then reads
// as all ones and the remainder as the captured dividend.
// Optional feature macro: DIV_SIGNED_EN. When defined, the operands are
// two's-complement and an extra FIX cycle restores the result signs (truncating
// division). When undefined, the divider is unsigned only.
module division_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] neg_fn(input logic [WIDTH-1:0] x);
        neg_fn = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a two's-complement value. The most-negative value maps to
    // itself, and that is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_fn(input logic [WIDTH-1:0] x);
        abs_fn = x[WIDTH-1] ? neg_fn(x) : x;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    // acc holds the dividend. Its bits shift out at the MSB while quotient
    // bits shift in at the LSB.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] prem_q, prem_d;     // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;       // captured divisor (magnitude)
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;         // captured divisor was zero
`ifdef DIV_SIGNED_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
`endif
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;
    logic [WIDTH-1:0] new_rem_s;
    logic [WIDTH-1:0] new_quo_s;

    // One restoring step. The shifted remainder can reach WIDTH+1 bits. When
    // its top bit is set the subtraction always succeeds, so the sign of the
    // WIDTH+1-bit difference alone decides the quotient bit.
    assign shifted_s = {prem_q, acc_q[WIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, dvs_q};
    assign ge_s      = ~diff_s[WIDTH];
    assign new_rem_s = ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
    assign new_quo_s = {acc_q[WIDTH-2:0], ge_s};

    // Next-state logic: acceptance, iteration, and the result write.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        prem_d      = prem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        dz_d        = dz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        ready_d     = ready_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ready_d = 1'b0;
                    cnt_d   = CW'(WIDTH - 1);
                    prem_d  = {WIDTH{1'b0}};
                    state_d = ST_CALC;
                    if (divisor == {WIDTH{1'b0}}) begin
                        // Keep the raw dividend so it is reported unchanged.
                        dz_d  = 1'b1;
                        acc_d = dividend;
                        dvs_d = divisor;
                    end else begin
                        dz_d  = 1'b0;
`ifdef DIV_SIGNED_EN
                        acc_d     = abs_fn(dividend);
                        dvs_d     = abs_fn(divisor);
                        neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d = dividend[WIDTH-1];
`else
                        acc_d = dividend;
                        dvs_d = divisor;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                if (dz_q) begin
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = acc_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    acc_d  = new_quo_s;
                    prem_d = new_rem_s;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == {CW{1'b0}}) begin
`ifdef DIV_SIGNED_EN
                        state_d = ST_FIX;
`else
                        quotient_d  = new_quo_s;
                        remainder_d = new_rem_s;
                        dbz_d       = 1'b0;
                        done_d      = 1'b1;
                        ready_d     = 1'b1;
                        state_d     = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end

`ifdef DIV_SIGNED_EN
            ST_FIX: begin
                quotient_d  = neg_quo_q ? neg_fn(acc_q)  : acc_q;
                remainder_d = neg_rem_q ? neg_fn(prem_q) : prem_q;
                dbz_d       = 1'b0;
                done_d      = 1'b1;
                ready_d     = 1'b1;
                state_d     = ST_IDLE;
            end
`endif

            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= {WIDTH{1'b0}};
            prem_q      <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            dz_q        <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            prem_q      <= prem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
            ready_q     <= ready_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_division_seq.sv
// Directed bench for division_seq at the default 64-bit width.
// Expected values are hand-computed. The back-to-back run uses the native
// unsigned / and % operators.
module tb_division_seq;

    localparam int W = 64;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int ops_exp = 0;

    division_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one operation: accept, wait (bounded) for done, then check latency,
    // results and the one-cycle done pulse.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic z, input int lat);
        int n;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        ops_exp++;
        chk({tag, "_busy"}, W'(ready), W'(1'b0));
        n = 0;
        while (done !== 1'b1 && n < lat + 10) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, W'(n), W'(lat));
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dbz"}, W'(div_by_zero), W'(z));
        chk({tag, "_rdy"}, W'(ready), W'(1'b1));
        tick();
        chk({tag, "_pulse"}, W'(done), W'(1'b0));
    endtask

    initial begin
        int n;
        logic [W-1:0] a, b, ea, eb;

        // Reset state
        tick();
        tick();
        chk("rst_ready", W'(ready), W'(1'b1));
        chk("rst_done", W'(done), W'(1'b0));
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);
        chk("rst_dbz", W'(div_by_zero), W'(1'b0));
        reset = 1'b0;
        tick();

        // Dividend smaller than divisor
        run_op("t17_27", 64'd17, 64'd27, 64'd0, 64'd17, 1'b0, LAT);

        // 100 / 7, with start toggled and operands changed while busy
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        ops_exp++;
        n = 0;
        while (done !== 1'b1 && n < LAT + 10) begin
            tick();
            n++;
            if (n == 10) begin
                start    = 1'b1;
                dividend = 64'd999;
                divisor  = 64'd3;
            end
            if (n == 11) start = 1'b0;
            if (n == 20) begin
                chk("hold_q", quotient, 64'd0);
                chk("hold_r", remainder, 64'd17);
                chk("hold_rdy", W'(ready), W'(1'b0));
            end
        end
        chk("t100_lat", W'(n), W'(LAT));
        chk("t100_q", quotient, 64'd14);
        chk("t100_r", remainder, 64'd2);
        chk("t100_dbz", W'(div_by_zero), W'(1'b0));
        tick();
        chk("t100_pulse", W'(done), W'(1'b0));
        chk("t100_noqueue", W'(ready), W'(1'b1));

        // Divide by zero
        run_op("tdz", 64'd55, 64'd0, {W{1'b1}}, 64'd55, 1'b1, 1);

        // Back-to-back with start held high
        a = 64'd17;
        b = 64'd27;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            ea = a;
            eb = b;
            a  = a * 64'd5;
            b  = b * 64'd3;
            dividend = a;
            divisor  = b;
            ops_exp++;
            n = 0;
            while (done !== 1'b1 && n < LAT + 10) begin
                tick();
                n++;
            end
            chk($sformatf("b2b%0d_lat", i), W'(n), W'(LAT));
            chk($sformatf("b2b%0d_q", i), quotient, ea / eb);
            chk($sformatf("b2b%0d_r", i), remainder, ea % eb);
            chk($sformatf("b2b%0d_dbz", i), W'(div_by_zero), W'(1'b0));
            if (i == 19) start = 1'b0;
            tick();
            chk($sformatf("b2b%0d_pulse", i), W'(done), W'(1'b0));
            chk($sformatf("b2b%0d_rdy", i), W'(ready), (i == 19) ? W'(1'b1) : W'(1'b0));
        end

        // Reset in the middle of a calculation
        dividend = 64'd1000;
        divisor  = 64'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_ready", W'(ready), W'(1'b1));
        chk("mrst_q", quotient, 64'd0);
        chk("mrst_r", remainder, 64'd0);
        chk("mrst_done", W'(done), W'(1'b0));
        chk("mrst_dbz", W'(div_by_zero), W'(1'b0));
        tick();
        reset = 1'b0;
        tick();
        run_op("t9_4", 64'd9, 64'd4, 64'd2, 64'd1, 1'b0, LAT);

`ifdef DIV_SIGNED_EN
        run_op("s_m17_5", ~64'd17 + 64'd1, 64'd5, ~64'd3 + 64'd1, ~64'd2 + 64'd1, 1'b0, LAT);
        run_op("s_17_m5", 64'd17, ~64'd5 + 64'd1, ~64'd3 + 64'd1, 64'd2, 1'b0, LAT);
        a = {1'b1, 63'd0};
        run_op("s_min_m1", a, {W{1'b1}}, a, 64'd0, 1'b0, LAT);
`endif

        tick();
        chk("done_count", W'(done_cnt), W'(ops_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
